// File: rtl/edge_detect_pkg.sv
`default_nettype none
// edge_detect_pkg -- shared enums, widths and helpers for the 3x3 edge detector.
// Rev 1.0
package edge_detect_pkg;

  typedef enum logic {
    KERN_SOBEL   = 1'b0,
    KERN_PREWITT = 1'b1
  } kernel_e;

  typedef enum logic {
    MAG_SUM = 1'b0,
    MAG_MAX = 1'b1
  } mag_mode_e;

  typedef enum logic [1:0] {
    ST_WAIT_LOW   = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } frame_state_e;

  // GRAD_W and MAG_W depend on the instance pixel width.
  function automatic int grad_w(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int mag_w(input int data_width);
    return data_width + 3;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_2line.sv
`default_nettype none
// line_buffer_2line -- two-line RAM returning the row-1 and row-2 pixels of a column.
// Rev 1.0
module line_buffer_2line
  import edge_detect_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [addr_w(DEPTH)-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]       i_din,
  output logic [DATA_WIDTH-1:0]       o_tap1,
  output logic [DATA_WIDTH-1:0]       o_tap2
);

  logic [DATA_WIDTH-1:0] r_row1 [DEPTH];
  logic [DATA_WIDTH-1:0] r_row2 [DEPTH];

  // Taps are read before the write so the window sees the previous rows.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_row1[i_addr] <= i_din;
      r_row2[i_addr] <= r_row1[i_addr];
    end
  end

  assign o_tap1 = r_row1[i_addr];
  assign o_tap2 = r_row2[i_addr];

endmodule
`default_nettype wire

// File: rtl/edge_detect_3x3.sv
`default_nettype none
// edge_detect_3x3 -- Sobel/Prewitt 3x3 edge detector with frame-latched configuration.
// Rev 1.0
module edge_detect_3x3
  import edge_detect_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int IMG_WIDTH      = 640,
  parameter int DEFAULT_THRESH = 128
) (
  input  logic                    clk,
  input  logic                    reset_p,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    din_valid,
  input  logic                    din_hsync,
  input  logic                    din_vsync,
  input  logic                    cfg_mode,
  input  logic                    cfg_mag,
  input  logic [DATA_WIDTH+2:0]   cfg_thresh,
  input  logic                    cfg_invert,
  output logic                    edge_bin,
  output logic [DATA_WIDTH-1:0]   edge_mag,
  output logic                    dout_valid,
  output logic                    dout_hsync,
  output logic                    dout_vsync
);

  localparam int GRAD_W = grad_w(DATA_WIDTH);
  localparam int MAG_W  = mag_w(DATA_WIDTH);
  localparam int AW     = addr_w(IMG_WIDTH);
  localparam int COL_W  = $clog2(IMG_WIDTH + 1);
  localparam logic [COL_W-1:0] c_COL_END = COL_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] c_COL_TWO = COL_W'(2);
  localparam logic [MAG_W-1:0] c_MAG_LIM = {{(MAG_W-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic w_line, w_accept, w_col_in, w_lb_we, w_active, w_latch, w_border_in;
  logic [AW-1:0] w_lb_addr;
  logic [DATA_WIDTH-1:0] w_tap1, w_tap2;
  logic [COL_W-1:0] r_col;
  logic [1:0] r_row;
  logic r_hsync_d;
  frame_state_e r_state, w_state_next;
  kernel_e r_sh_mode;
  mag_mode_e r_sh_mag;
  logic [MAG_W-1:0] r_sh_thr;
  logic r_sh_inv;
  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic [2:0] r_ctl1, r_ctl2, r_ctl3;
  logic r_border1, r_border2;
  logic w_sobel;
  logic [GRAD_W-1:0] w_left, w_right, w_top, w_bot, r_gx, r_gy;
  logic [MAG_W-1:0] w_g;
  logic w_is_edge;
  logic r_edge_bin;
  logic [DATA_WIDTH-1:0] r_edge_mag;

  assign w_line    = din_hsync && din_vsync;
  assign w_accept  = din_valid && w_line;
  assign w_col_in  = (r_col < c_COL_END);
  assign w_lb_we   = w_accept && w_col_in;
  assign w_lb_addr = w_col_in ? r_col[AW-1:0] : '0;

  line_buffer_2line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb (
    .clk   (clk),
    .i_we  (w_lb_we),
    .i_addr(w_lb_addr),
    .i_din (din),
    .o_tap1(w_tap1),
    .o_tap2(w_tap2)
  );

  // Row saturates at 3: only the "first two rows" distinction matters.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_col     <= '0;
      r_row     <= '0;
      r_hsync_d <= 1'b0;
    end else begin
      r_hsync_d <= din_hsync;
      if (!din_hsync)                             r_col <= '0;
      else if (w_accept && (r_col != c_COL_END))  r_col <= r_col + 1'b1;
      if (!din_vsync)                                          r_row <= '0;
      else if (r_hsync_d && !din_hsync && (r_row != 2'd3))     r_row <= r_row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= ST_WAIT_LOW;
    else         r_state <= w_state_next;
  end

  // WAIT_FRAME is only entered with vsync low, so vsync high there is a rising edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_LOW:   if (!din_vsync) w_state_next = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (din_vsync)  w_state_next = ST_ACTIVE;
      ST_ACTIVE:     if (!din_vsync) w_state_next = ST_WAIT_FRAME;
      default:       w_state_next = ST_WAIT_LOW;
    endcase
  end

  always_comb begin
    w_latch  = (r_state == ST_WAIT_FRAME) && din_vsync;
    w_active = (r_state == ST_ACTIVE) || w_latch;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_sh_mode <= KERN_SOBEL;
      r_sh_mag  <= MAG_SUM;
      r_sh_thr  <= MAG_W'(DEFAULT_THRESH);
      r_sh_inv  <= 1'b0;
    end else if (w_latch) begin
      r_sh_mode <= kernel_e'(cfg_mode);
      r_sh_mag  <= mag_mode_e'(cfg_mag);
      r_sh_thr  <= cfg_thresh;
      r_sh_inv  <= cfg_invert;
    end
  end

  // Window: column 2 is the newest, row 2 is the current line.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
    end else if (!w_line) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) r_win[i][j] <= '0;
    end else if (din_valid) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_tap2;
      r_win[1][2] <= w_tap1;
      r_win[2][2] <= din;
    end
  end

  assign w_border_in = !(w_active && w_line && (r_row >= 2'd2) &&
                         (r_col >= c_COL_TWO) && w_col_in);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_ctl1 <= '0;
      r_ctl2 <= '0;
      r_ctl3 <= '0;
    end else begin
      r_ctl1 <= {din_valid, din_hsync, din_vsync};
      r_ctl2 <= r_ctl1;
      r_ctl3 <= r_ctl2;
    end
  end

  function automatic logic [GRAD_W-1:0] wsum(input logic [DATA_WIDTH-1:0] a,
                                             input logic [DATA_WIDTH-1:0] m,
                                             input logic [DATA_WIDTH-1:0] b,
                                             input logic sobel);
    logic [GRAD_W-1:0] mid;
    mid = GRAD_W'(m);
    if (sobel) mid = mid << 1;
    return GRAD_W'(a) + mid + GRAD_W'(b);
  endfunction

  function automatic logic [GRAD_W-1:0] absdiff(input logic [GRAD_W-1:0] x,
                                                input logic [GRAD_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  always_comb begin
    w_sobel = (r_sh_mode == KERN_SOBEL);
    w_left  = wsum(r_win[0][0], r_win[1][0], r_win[2][0], w_sobel);
    w_right = wsum(r_win[0][2], r_win[1][2], r_win[2][2], w_sobel);
    w_top   = wsum(r_win[0][0], r_win[0][1], r_win[0][2], w_sobel);
    w_bot   = wsum(r_win[2][0], r_win[2][1], r_win[2][2], w_sobel);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_border1 <= 1'b1;
      r_border2 <= 1'b1;
      r_gx      <= '0;
      r_gy      <= '0;
    end else begin
      if (din_valid) r_border1 <= w_border_in;
      if (r_ctl1[2]) begin
        r_border2 <= r_border1;
        r_gx      <= absdiff(w_right, w_left);
        r_gy      <= absdiff(w_top, w_bot);
      end
    end
  end

  always_comb begin
    if (r_sh_mag == MAG_MAX) w_g = (r_gx >= r_gy) ? MAG_W'(r_gx) : MAG_W'(r_gy);
    else                     w_g = MAG_W'(r_gx) + MAG_W'(r_gy);
    w_is_edge = (w_g > r_sh_thr);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_edge_bin <= 1'b0;
      r_edge_mag <= '0;
    end else if (r_ctl2[2]) begin
      if (r_border2) begin
        r_edge_bin <= !r_sh_inv;
        r_edge_mag <= '0;
      end else begin
        r_edge_bin <= r_sh_inv ? w_is_edge : !w_is_edge;
        r_edge_mag <= (w_g > c_MAG_LIM) ? {DATA_WIDTH{1'b1}} : w_g[DATA_WIDTH-1:0];
      end
    end
  end

  assign edge_bin   = r_edge_bin;
  assign edge_mag   = r_edge_mag;
  assign dout_valid = r_ctl3[2];
  assign dout_hsync = r_ctl3[1];
  assign dout_vsync = r_ctl3[0];

endmodule
`default_nettype wire

// File: doc/edge_detect_3x3.md
# edge_detect_3x3

Parametrised 3×3 gradient edge detector for the grayscale video pipeline, placed directly after the median filter. It accepts a valid/hsync/vsync pixel stream and produces two per-pixel results from Sobel or Prewitt kernels: a binary edge decision and a saturated gradient magnitude. Kernel, magnitude mode, threshold and polarity are selectable at run time and are latched per frame. Image borders are handled deterministically. A frame-sync state machine keeps output from starting in the middle of a frame.

## Interface
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 640, active pixels per line; sets the line-buffer depth.
- DEFAULT_THRESH, 128, threshold loaded at reset.
- clk  in  1  clock.
- reset_p  in  1  reset, asynchronous, active-high.
- din  in  DATA_WIDTH  grayscale pixel.
- din_valid / din_hsync / din_vsync  in  1  pixel qualifier, line-active flag, frame-active flag.
- cfg_mode  in  1  kernel select: 0 = Sobel, 1 = Prewitt.
- cfg_mag  in  1  magnitude select: 0 = |Gx|+|Gy|, 1 = max(|Gx|,|Gy|).
- cfg_thresh  in  DATA_WIDTH+3  edge threshold.
- cfg_invert  in  1  polarity: 0 = edge is 0 (black), 1 = edge is 1.
- edge_bin  out  1  binary result.
- edge_mag  out  DATA_WIDTH  gradient magnitude, saturated to 2^DATA_WIDTH−1.
- dout_valid / dout_hsync / dout_vsync  out  1  control signals delayed to align with the data outputs.

## Operation
- **Line buffer**: two-line buffer with depth IMG_WIDTH. It is written and read only on din_valid and produces the pixel from one row above and from two rows above at the current column.
- **Window**: 3×3 register array that shifts one column per din_valid while din_hsync && din_vsync. It clears to 0 when hsync or vsync is low.
- **Counters**:
  - col increments per accepted pixel and clears on hsync low.
  - row increments on the hsync falling edge and clears on vsync low.
- **Frame FSM**:
  - WAIT_LOW: after reset; go to WAIT_FRAME when din_vsync = 0.
  - WAIT_FRAME: on the din_vsync rising edge, latch the cfg_* inputs into shadow registers and go to ACTIVE.
  - ACTIVE: on the din_vsync falling edge, go to WAIT_FRAME.
  - Outside ACTIVE, results are forced to the border value.
- **Border rule**: a window whose newest pixel has row<2, col<2 or col≥IMG_WIDTH yields the border value: edge_mag = 0, edge_bin = non-edge level. Pixels with col≥IMG_WIDTH do not write the line buffer.
- **Output geometry**: the result emitted for input (r,c) describes the window centre (r−1,c−1). There is exactly one output per input valid, so the pixel count is preserved.
- **Kernels**: centre weight 2 for Sobel, 1 for Prewitt.
  - Gx = right column − left column.
  - Gy = top row − bottom row.
  - Absolute value is taken by comparing the two weighted sums, then subtracting the smaller from the larger. Each result is DATA_WIDTH+2 bits.
- **Magnitude**: G is DATA_WIDTH+3 bits. Edge if G > threshold_shadow (strictly greater). edge_mag = min(G, 2^DATA_WIDTH−1).
- **Shadow registers**: reset to Sobel, sum mode, DEFAULT_THRESH, invert 0. Changing cfg_* mid-frame has no effect until the next frame start.

## Timing
- Pipeline of 3 stages:
  - S1: window update.
  - S2: registered |Gx| and |Gy|.
  - S3: registered edge_bin and edge_mag.
- dout_valid/hsync/vsync equal din_valid/hsync/vsync delayed exactly 3 clk. Gaps in din_valid are reproduced unchanged.
- The pipeline runs every cycle with no back-pressure. Data stages load only when their delayed valid is high and otherwise hold.
- **Reset values**: all outputs 0, window 0, counters 0, FSM in WAIT_LOW, control delay line 0.
- **Reset during a frame**: output stays at border value until a complete vsync low→high sequence has been seen.
- **vsync rising edge and din_valid in the same cycle**: that pixel already belongs to ACTIVE and uses the newly latched configuration.
- **Throughput**: 1 pixel per clk.

## Structure
- Package edge_detect_pkg holds:
  - kernel enum (KERN_SOBEL, KERN_PREWITT);
  - magnitude enum (MAG_SUM, MAG_MAX);
  - FSM state enum;
  - widths GRAD_W = DATA_WIDTH+2 and MAG_W = DATA_WIDTH+3.
- Sub-module line_buffer_2line (parameters DATA_WIDTH, DEPTH): inferred block RAM with write-enable, returning the row−1 and row−2 taps.
- The top level contains the counters, FSM, window, arithmetic and control delay line.

## Test plan
- **Flat image**: 8×6 frame (IMG_WIDTH=8), all pixels 100, threshold 128 → every interior edge_mag = 0, edge_bin = 1; border pixels also report 0/1.
- **Vertical step**: columns 0–3 = 0, columns 4–7 = 255.
  - Sobel: interior centres adjacent to the step give edge_mag = 255 (|Gx| = 1020, saturated), edge_bin = 0.
  - Prewitt with max mode: |Gx| = 765.
- **Threshold boundary**: a window producing G = 128 with threshold 128 → edge_bin = 1; threshold 127 → edge_bin = 0; cfg_invert = 1 flips both results.
- **Latency and gaps**: insert din_valid low cycles within a line → dout_valid pattern is identical, 3 clk later; output pixel count equals input count.
- **Mid-frame configuration change**: set cfg_thresh to 0 at row 3 → results unchanged until the next vsync rising edge, after which every interior non-flat pixel is an edge.
- **Reset mid-frame**: assert reset_p at row 2 → all outputs 0 immediately; the remainder of that frame outputs the border value; the next frame is processed normally.
